fp_accumulator: RTL and testbench

- Sequential neuron-sum stage that sits directly upstream of the combinational FP32 adder and consumes its result.
- Accepts a stream of IEEE754 single-precision products over a valid/ready handshake and feeds the running sum plus the current term into the adder.
- Registers the adder output each cycle and emits one FP32 neuron pre-activation per job, with optional ReLU.
- The adder is instantiated outside this block and connected through the adder_* ports.

---
 rtl/fp_accumulator.sv | 80 ++++++++
 tb/tb_fp_accumulator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// Running-sum stage feeding an external FP32 adder; one neuron
// pre-activation per job, optional ReLU on the final sum.
module fp_accumulator #(
    parameter int LEN_W   = 16,
    parameter bit RELU_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic [31:0]      adder_a,
    output logic [31:0]      adder_b,
    input  logic [31:0]      adder_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_special,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [31:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic             special;
    logic             acc_nan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= 32'h0;
            cnt     <= '0;
            special <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= bias;
                        cnt     <= length;
                        special <= (bias[30:23] == 8'hFF);
                        state   <= (length == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc     <= adder_result;
                        cnt     <= cnt - 1'b1;
                        special <= special | (in_data[30:23] == 8'hFF);
                        if (cnt == LEN_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NaN keeps its sign through ReLU; everything else negative clamps to +0
    assign acc_nan = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'h0);

    assign adder_a     = acc;
    assign adder_b     = in_data;
    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_special = special;
    assign out_data    = (RELU_EN && acc[31] && !acc_nan) ? 32'h0 : acc;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: two instances (ReLU off/on) on shared
// stimulus, each with a behavioural FP32 adder built on real arithmetic.
module tb_fp_accumulator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] length;
    logic [31:0] bias;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic [31:0] adder_a0, adder_a1, adder_b0, adder_b1;
    logic [31:0] adder_res0, adder_res1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_data0, out_data1;
    logic        out_special0, out_special1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    logic [31:0] terms[$];

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'h00)
            d = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF)
            d = {f[31], 11'h7FF, f[22:0], 29'b0};
        else begin
            e = {3'b0, f[30:23]} + 11'd896;
            d = {f[31], e, f[22:0], 29'b0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] m;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047)
            return {d[63], 8'hFF, d[51:29]};
        if (e == 0)
            return {d[63], 31'b0};
        e = e - 1023 + 127;
        m = {1'b0, d[51:29]};
        if (d[28] && ((d[27:0] != 28'h0) || d[29]))
            m = m + 24'd1;
        if (m[23]) begin
            m = 24'h0;
            e = e + 1;
        end
        if (e >= 255)
            return {d[63], 8'hFF, 23'b0};
        if (e <= 0)
            return {d[63], 31'b0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
        if (x[31] && !((x[30:23] == 8'hFF) && (x[22:0] != 0)))
            return 32'h0;
        return x;
    endfunction

    function automatic bit is_spec(input logic [31:0] x);
        return x[30:23] == 8'hFF;
    endfunction

    assign adder_res0 = fadd(adder_a0, adder_b0);
    assign adder_res1 = fadd(adder_a1, adder_b1);

    fp_accumulator #(.LEN_W(16), .RELU_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .adder_a(adder_a0), .adder_b(adder_b0),
        .adder_result(adder_res0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0),
        .out_special(out_special0), .busy(busy0)
    );

    fp_accumulator #(.LEN_W(16), .RELU_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .bias(bias), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .adder_a(adder_a1), .adder_b(adder_b1),
        .adder_result(adder_res1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1),
        .out_special(out_special1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic run_job(input string nm, input logic [31:0] b,
                           input int gmin, input int gmax, input int bp,
                           input bit hs_start, input logic [31:0] e0,
                           input logic [31:0] e1, input bit esp);
        int n, idx, cyc, last, gap;
        logic [31:0] racc, hold;
        n = terms.size();
        racc = b;
        @(negedge clk);
        start = 1'b1;
        length = 16'(n);
        bias = b;
        @(negedge clk);
        start = 1'b0;
        chk1({nm, ":busy_after_start"}, busy0, 1'b1);
        chk1({nm, ":busy1_after_start"}, busy1, 1'b1);
        idx = 0; cyc = 0; last = -1; gap = 0;
        while (cyc < 1000) begin
            if (out_valid0) break;
            chk({nm, ":acc"}, adder_a0, racc);
            if (idx < n && gap == 0) begin
                in_valid = 1'b1;
                in_data = terms[idx];
            end else begin
                in_valid = 1'b0;
                in_data = $urandom;
                if (gap > 0) gap--;
            end
            #1;
            chk({nm, ":adder_b"}, adder_b1, in_data);
            if (idx == n)
                chk1({nm, ":ready_after_last"}, in_ready0, 1'b0);
            if (in_valid && in_ready0) begin
                racc = fadd(racc, terms[idx]);
                idx++;
                last = cyc;
                gap = int'($urandom_range(gmax, gmin));
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk1({nm, ":out_valid"}, out_valid0, 1'b1);
        chk({nm, ":latency"}, cyc - last, 1);
        chk({nm, ":accepts"}, idx, n);
        chk1({nm, ":in_ready_done"}, in_ready1, 1'b0);
        hold = out_data0;
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            start = (k == 1);
            length = 16'd1;
            bias = $urandom;
            @(negedge clk);
            chk1({nm, ":bp_valid"}, out_valid0, 1'b1);
            chk1({nm, ":bp_busy"}, busy0, 1'b1);
            chk({nm, ":bp_stable"}, out_data0, hold);
        end
        start = 1'b0;
        chk({nm, ":out_data"}, out_data0, e0);
        chk({nm, ":out_data_relu"}, out_data1, e1);
        chk1({nm, ":out_valid_relu"}, out_valid1, 1'b1);
        chk1({nm, ":special"}, out_special0, esp);
        chk1({nm, ":special_relu"}, out_special1, esp);
        out_ready = 1'b1;
        start = hs_start;
        length = 16'd1;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk1({nm, ":idle_busy"}, busy0, 1'b0);
        chk1({nm, ":idle_valid"}, out_valid0, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] bias;
        int          n;
        logic [31:0] term;
        int          gmin;
        int          gmax;
        int          bp;
        bit          hs_start;
        logic [31:0] e0;
        logic [31:0] e1;
        bit          sp;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{"sum4",    32'h3F800000, 4, 32'h3F800000, 0, 0, 0, 0, 32'h40A00000, 32'h40A00000, 0};
        vt[1] = '{"stall",   32'h3F800000, 4, 32'h3F800000, 3, 3, 0, 0, 32'h40A00000, 32'h40A00000, 0};
        vt[2] = '{"empty",   32'hC0400000, 0, 32'h0,        0, 0, 0, 0, 32'hC0400000, 32'h00000000, 0};
        vt[3] = '{"relu",    32'h00000000, 1, 32'hC0000000, 0, 0, 0, 0, 32'hC0000000, 32'h00000000, 0};
        vt[4] = '{"nan",     32'h00000000, 1, 32'h7FC00000, 0, 0, 0, 0, 32'h7FC00000, 32'h7FC00000, 1};
        vt[5] = '{"bp",      32'h3F800000, 4, 32'h3F800000, 0, 1, 5, 1, 32'h40A00000, 32'h40A00000, 0};
        vt[6] = '{"negzero", 32'h80000000, 0, 32'h0,        0, 0, 2, 0, 32'h80000000, 32'h00000000, 0};
        vt[7] = '{"negsum",  32'hBF800000, 2, 32'hBF800000, 0, 2, 1, 1, 32'hC0400000, 32'h00000000, 0};

        reset = 1'b1;
        start = 1'b0;
        length = 16'd0;
        bias = 32'h0;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        chk1("rst:in_ready", in_ready0, 1'b0);
        chk1("rst:out_valid", out_valid0, 1'b0);
        chk("rst:out_data", out_data0, 32'h0);
        chk1("rst:special", out_special0, 1'b0);
        chk1("rst:busy", busy0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            terms.delete();
            for (int i = 0; i < vt[v].n; i++)
                terms.push_back(vt[v].term);
            run_job(vt[v].name, vt[v].bias, vt[v].gmin, vt[v].gmax,
                    vt[v].bp, vt[v].hs_start, vt[v].e0, vt[v].e1, vt[v].sp);
        end

        // abort a job after two terms with an infinite bias in flight
        @(negedge clk);
        start = 1'b1;
        length = 16'd4;
        bias = 32'h7F800000;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h3F800000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk1("abort:special_before", out_special0, 1'b1);
        reset = 1'b1;
        #1;
        chk1("abort:in_ready", in_ready0, 1'b0);
        chk1("abort:out_valid", out_valid0, 1'b0);
        chk("abort:out_data", out_data0, 32'h0);
        chk1("abort:special", out_special0, 1'b0);
        chk1("abort:busy", busy0, 1'b0);
        chk("abort:acc", adder_a0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        terms.delete();
        repeat (4) terms.push_back(32'h3F800000);
        run_job("after_abort", 32'h3F800000, 0, 0, 0, 0,
                32'h40A00000, 32'h40A00000, 0);

        for (int j = 0; j < 25; j++) begin
            logic [31:0] b, t, exp;
            bit sp;
            int n;
            b = r2f(real'(int'($urandom_range(200)) - 100));
            exp = b;
            sp = is_spec(b);
            n = int'($urandom_range(8));
            terms.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(15) == 0)
                    t = 32'h7F800000;
                else
                    t = r2f(real'(int'($urandom_range(200)) - 100));
                terms.push_back(t);
                exp = fadd(exp, t);
                sp = sp | is_spec(t);
            end
            run_job($sformatf("rand%0d", j), b, 0, int'($urandom_range(2)),
                    int'($urandom_range(3)), 1'($urandom_range(1)),
                    exp, relu(exp), sp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
